// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer: FSM states, op codes
// and the nibble width of the time-multiplexed adder.
package nibble_serial_alu_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/nibble_serial_alu_ctrl_adder.sv
// 4-bit ripple adder shared by every nibble step of the serial ALU.
module Adder_4bit (
  input  logic [3:0] num_1,
  input  logic [3:0] num_2,
  input  logic       c,
  output logic [3:0] sum,
  output logic       carry
);
  assign {carry, sum} = {1'b0, num_1} + {1'b0, num_2} + {4'b0000, c};
endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-nibble add/subtract sequencer: one 4-bit adder walks the operand
// words LSB nibble first, carry held in a register between steps.
module nibble_serial_alu_ctrl
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter int WORD_NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NIBBLE_W*WORD_NIBBLES-1:0] num_1,
  input  logic [NIBBLE_W*WORD_NIBBLES-1:0] num_2,
  input  logic                            op,
  input  logic                            c,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NIBBLE_W*WORD_NIBBLES-1:0] sum,
  output logic                            carry,
  output logic                            overflow,
  output logic                            zero,
  output logic                            busy
);
  localparam int W     = NIBBLE_W * WORD_NIBBLES;
  localparam int IDX_W = $clog2(WORD_NIBBLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_NIBBLES - 1);

  logic [1:0]          state;
  logic [IDX_W-1:0]    idx;
  logic                cy;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_carry;
  logic [W-1:0]        sum_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operands are data only; the FSM guarantees they are reloaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= num_1;
      b_q <= (op == OP_SUB) ? ~num_2 : num_2;
    end
  end

  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    sum_next = sum;
    for (int i = 0; i < WORD_NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
        sum_next[NIBBLE_W*i +: NIBBLE_W] = add_sum;
      end
    end
  end

  Adder_4bit u_adder (
    .num_1 (a_nib),
    .num_2 (b_nib),
    .c     (cy),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cy       <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            idx   <= '0;
            cy    <= (op == OP_SUB) ? 1'b1 : c;
          end
        end
        RUN: begin
          sum <= sum_next;
          cy  <= add_carry;
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            carry    <= add_carry;
            // add_sum is the top nibble here, so its bit 3 is the word sign.
            overflow <= (a_q[W-1] == b_q[W-1]) && (add_sum[NIBBLE_W-1] != a_q[W-1]);
            zero     <= (sum_next == '0);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Bench for nibble_serial_alu_ctrl with WORD_NIBBLES=4 (16-bit words).
module tb_nibble_serial_alu_ctrl;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] num_1 = '0;
  logic [W-1:0] num_2 = '0;
  logic         op = 1'b0;
  logic         c = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  nibble_serial_alu_ctrl #(.WORD_NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num_1(num_1), .num_2(num_2), .op(op), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry(carry), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         o;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference from plain integer arithmetic on whole words.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic o, input logic ci,
                                output logic [W-1:0] s, output logic co,
                                output logic ov, output logic z);
    logic [31:0] full;
    int ua, ub, sa, sb, sr;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (!o) begin
      full = ua + ub + (ci ? 1 : 0);
      sr   = sa + sb + (ci ? 1 : 0);
    end else begin
      full = ua + (65535 - ub) + 1;
      sr   = sa - sb;
    end
    s  = full[W-1:0];
    co = full[W];
    ov = (sr > 32767) || (sr < -32768);
    z  = (s == '0);
  endfunction

  // Issue one word, measure latency, check result, then drain with out_ready.
  task automatic run_word(input string name, input vec_t v);
    int lat;
    @(negedge clk);
    check({name, ".in_ready"}, in_ready, 1);
    num_1 = v.a; num_2 = v.b; op = v.o; c = v.ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".latency"}, lat, N);
    @(negedge clk);
    check({name, ".sum"}, sum, v.s);
    check({name, ".carry"}, carry, v.co);
    check({name, ".overflow"}, overflow, v.ov);
    check({name, ".zero"}, zero, v.z);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ".idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t v;
    int acc_cyc[$];
    vec_t expq[$];
    int issued;
    int got;
    logic [W-1:0] held;

    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

    // Reset state
    #2;
    check("reset.outs", {sum, carry, overflow, zero, out_valid, busy}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.in_ready", in_ready, 1);

    foreach (tbl[i]) run_word($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 20; i++) begin
      v.a  = W'($urandom);
      v.b  = W'($urandom);
      v.o  = 1'($urandom);
      v.ci = 1'($urandom);
      model(v.a, v.b, v.o, v.ci, v.s, v.co, v.ov, v.z);
      run_word($sformatf("rand%0d", i), v);
    end

    // Backpressure: result and handshake frozen while out_ready is low
    @(negedge clk);
    num_1 = 16'h1234; num_2 = 16'h0FFF; op = 1'b0; c = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    check("bp.out_valid", out_valid, 1);
    held = sum;
    check("bp.sum0", held, 16'h2233);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      num_1 = W'($urandom);
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d", k), {sum, carry, overflow, zero, out_valid, in_ready},
            {16'h2233, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.release", {out_valid, in_ready, busy}, 3'b010);

    // Reset mid-run aborts with no partial result
    @(negedge clk);
    num_1 = 16'h1234; num_2 = 16'h1111; op = 1'b0; c = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort.busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort.outs", {sum, carry, overflow, zero, out_valid, busy}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.in_ready", in_ready, 1);
    run_word("after_abort", '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0});

    // Back-to-back with in_valid held and out_ready tied high
    out_ready = 1'b1;
    issued = 0;
    got = 0;
    for (int t = 0; t < 60 && got < 3; t++) begin
      @(negedge clk);
      if (out_valid) begin
        v = expq.pop_front();
        check($sformatf("b2b%0d.sum", got), sum, v.s);
        check($sformatf("b2b%0d.flags", got), {carry, overflow, zero}, {v.co, v.ov, v.z});
        got++;
      end
      if (in_ready && issued < 3) begin
        v.a = W'($urandom); v.b = W'($urandom); v.o = 1'($urandom); v.ci = 1'($urandom);
        model(v.a, v.b, v.o, v.ci, v.s, v.co, v.ov, v.z);
        expq.push_back(v);
        num_1 = v.a; num_2 = v.b; op = v.o; c = v.ci;
        in_valid = 1'b1;
        acc_cyc.push_back(cyc);
        issued++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b.count", got, 3);
    if (acc_cyc.size() == 3) begin
      check("b2b.spacing1", acc_cyc[1] - acc_cyc[0], N + 2);
      check("b2b.spacing2", acc_cyc[2] - acc_cyc[1], N + 2);
    end else begin
      check("b2b.accepts", acc_cyc.size(), 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
